// File: rtl/dbus_arb_pkg.sv
// Shared definitions for the data-bus arbiter: state/owner codes and watchdog limits.
package dbus_arb_pkg;

  // State codes double as the externally visible owner code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CPU  = 2'b01,
    DMA  = 2'b10,
    TURN = 2'b11
  } arb_state_e;

  localparam int unsigned BURST_W  = 4;    // holds BURST_MAX up to 15
  localparam int unsigned WD_W     = 8;
  localparam int unsigned WD_LIMIT = 255;  // consecutive DMA cycles before forced release

endpackage

// File: rtl/arb_burst_ctr.sv
// Burst counter: counts owner cycles spent while the other requester waits,
// saturating at LIMIT. limit_o is a registered flag meaning "the next
// increment reaches LIMIT", so the FSM can release exactly on the LIMIT-th cycle.
module arb_burst_ctr
  import dbus_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_o
);

  logic [BURST_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < BURST_W'(LIMIT))) begin
      cnt_d = cnt_q + BURST_W'(1);
    end
  end

  // Count register and look-ahead limit flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      limit_o <= (LIMIT <= 1);
    end else begin
      cnt_q   <= cnt_d;
      limit_o <= (cnt_d >= BURST_W'(LIMIT - 1));
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter (core vs. loader/DMA) with burst fairness and a
// mandatory dead cycle on handover. Optional DMA watchdog enabled by defining
// DBUS_ARB_WATCHDOG_EN; without it wd_err is tied low.
module dbus_arbiter
  import dbus_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       dma_req,
  input  logic       dma_last,
  output logic       cpu_gnt,
  output logic       dma_gnt,
  output logic [1:0] owner,
  output logic       wd_err
);

  arb_state_e state_q, state_d;
  arb_state_e pend_q;
  logic       burst_clr, burst_inc, burst_near, burst_hit;
  logic       wd_fire;

  // Next-state rules; grants follow the registered state only.
  function automatic arb_state_e fsm_next(input arb_state_e st, input arb_state_e pend,
                                          input logic c, input logic d, input logic last,
                                          input logic hit, input logic wd);
    arb_state_e nxt;
    nxt = st;
    case (st)
      IDLE: begin
        if (c)      nxt = CPU;
        else if (d) nxt = DMA;
        else        nxt = IDLE;
      end
      CPU: begin
        if (!c)          nxt = d ? TURN : IDLE;
        else if (d && hit) nxt = TURN;
        else             nxt = CPU;
      end
      DMA: begin
        if (!d || last || wd) nxt = c ? TURN : IDLE;
        else if (c && hit)    nxt = TURN;
        else                  nxt = DMA;
      end
      TURN: begin
        if (pend == CPU) begin
          if (c)      nxt = CPU;
          else if (d) nxt = DMA;
          else        nxt = IDLE;
        end else begin
          if (d)      nxt = DMA;
          else if (c) nxt = CPU;
          else        nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  assign burst_clr = (state_q == IDLE) || (state_q == TURN);
  assign burst_inc = ((state_q == CPU) && dma_req) || ((state_q == DMA) && cpu_req);
  assign burst_hit = burst_inc && burst_near;
  assign state_d   = fsm_next(state_q, pend_q, cpu_req, dma_req, dma_last, burst_hit, wd_fire);

  arb_burst_ctr #(
    .LIMIT (BURST_MAX)
  ) u_burst_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (burst_clr),
    .inc_i   (burst_inc),
    .limit_o (burst_near)
  );

  // Arbiter state, pending owner and registered grant/owner outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= CPU;
      owner   <= 2'b00;
      cpu_gnt <= 1'b0;
      dma_gnt <= 1'b0;
    end else begin
      state_q <= state_d;
      owner   <= state_d;
      cpu_gnt <= (state_d == CPU);
      dma_gnt <= (state_d == DMA);
      if ((state_d == TURN) && (state_q != TURN)) begin
        if (state_q == CPU) pend_q <= DMA;
        else                pend_q <= CPU;
      end
    end
  end

`ifdef DBUS_ARB_WATCHDOG_EN
  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_err_q;

  assign wd_fire = (state_q == DMA) && (wd_cnt_q == WD_W'(WD_LIMIT - 1));
  assign wd_err  = wd_err_q;

  // Consecutive-DMA-cycle counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      if ((state_q == DMA) && (state_d == DMA)) wd_cnt_q <= wd_cnt_q + WD_W'(1);
      else                                      wd_cnt_q <= '0;
      if (wd_fire) wd_err_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign wd_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios plus random traffic against a
// behavioural model of grant ownership.
module tb_dbus_arbiter;

  localparam int unsigned BM = 4;
`ifdef DBUS_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, dma_req, dma_last;
  logic       cpu_gnt, dma_gnt, wd_err;
  logic [1:0] owner;

  int tests = 0;
  int fails = 0;

  // Model: who holds the bus (0 none, 1 core, 2 DMA), whether a dead cycle is
  // in progress, and bookkeeping for fairness and the watchdog.
  int m_own, m_turn, m_prev, m_pend, m_wait, m_run, m_wd;

  dbus_arbiter #(.BURST_MAX(BM)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .dma_last (dma_last),
    .cpu_gnt  (cpu_gnt),
    .dma_gnt  (dma_gnt),
    .owner    (owner),
    .wd_err   (wd_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_own = 0; m_turn = 0; m_prev = 1; m_pend = 1; m_wait = 0; m_run = 0; m_wd = 0;
  endtask

  task automatic release_bus(input bit via_turn);
    if (via_turn) begin
      m_turn = 1;
      m_prev = m_own;
      m_pend = 3 - m_own;
    end
    m_own = 0;
  endtask

  task automatic model_step(input bit c, input bit d, input bit l);
    bit fire;
    bit want [3];
    want[0] = 1'b0; want[1] = c; want[2] = d;
    if (m_turn != 0) begin
      m_turn = 0;
      if (want[m_pend])      m_own = m_pend;
      else if (want[m_prev]) m_own = m_prev;
      else                   m_own = 0;
      m_wait = 0; m_run = 0;
    end else if (m_own == 0) begin
      m_own  = c ? 1 : (d ? 2 : 0);
      m_wait = 0; m_run = 0;
    end else if (m_own == 1) begin
      if (d && m_wait < BM) m_wait++;
      if (!c)                      release_bus(d);
      else if (d && m_wait >= BM)  release_bus(1'b1);
    end else begin
      m_run++;
      if (c && m_wait < BM) m_wait++;
      fire = WD_EN && (m_run >= 255);
      if (fire) m_wd = 1;
      if (!d || l || fire)         release_bus(c);
      else if (c && m_wait >= BM)  release_bus(1'b1);
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] eo;
    eo = (m_turn != 0) ? 2'd3 : 2'(m_own);
    chk({tag, ".owner"},   owner, eo);
    chk({tag, ".cpu_gnt"}, {1'b0, cpu_gnt}, {1'b0, (eo == 2'd1)});
    chk({tag, ".dma_gnt"}, {1'b0, dma_gnt}, {1'b0, (eo == 2'd2)});
    chk({tag, ".wd_err"},  {1'b0, wd_err},  2'(m_wd));
    chk({tag, ".overlap"}, {1'b0, cpu_gnt & dma_gnt}, 2'd0);
  endtask

  task automatic cycle(input bit c, input bit d, input bit l, input string tag);
    cpu_req = c; dma_req = d; dma_last = l;
    model_step(c, d, l);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [1:0] pat;
    int p;
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; dma_last = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // Simultaneous request from idle goes to the core, then alternating bursts.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0, "burst");
      p = i % 10;
      pat = (p < 4) ? 2'd1 : (p == 4) ? 2'd3 : (p < 9) ? 2'd2 : 2'd3;
      chk("burst_seq", owner, pat);
    end
    cycle(1'b0, 1'b0, 1'b0, "drain");
    cycle(1'b0, 1'b0, 1'b0, "drain");

    // Three DMA beats, last on beat 3, core joins on beat 2.
    cycle(1'b0, 1'b1, 1'b0, "dma_b1"); chk("dma_b1_seq", owner, 2'd2);
    cycle(1'b0, 1'b1, 1'b0, "dma_b2"); chk("dma_b2_seq", owner, 2'd2);
    cycle(1'b1, 1'b1, 1'b0, "dma_b3"); chk("dma_b3_seq", owner, 2'd2);
    cycle(1'b1, 1'b1, 1'b1, "dma_tn"); chk("dma_tn_seq", owner, 2'd3);
    cycle(1'b1, 1'b0, 1'b0, "dma_cp"); chk("dma_cp_seq", owner, 2'd1);
    cycle(1'b0, 1'b0, 1'b0, "drain");

    // Asynchronous reset while DMA holds the bus.
    cycle(1'b0, 1'b1, 1'b0, "pre_rst");
    #2 reset = 1'b1;
    #1;
    chk("rst_async.dma_gnt", {1'b0, dma_gnt}, 2'd0);
    chk("rst_async.owner", owner, 2'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_all("rst_hold");
    cycle(1'b1, 1'b0, 1'b0, "after_rst");
    chk("after_rst_seq", owner, 2'd1);

    // Random traffic biased towards contention.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0), "rand");
    end

    // Long uninterrupted DMA request.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, "settle");
    repeat (300) cycle(1'b0, 1'b1, 1'b0, "wd_hold");
    chk("wd_final", {1'b0, wd_err}, {1'b0, WD_EN});

    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("final_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
